// File: rtl/writeback_arbiter.sv
// Per-channel result FIFOs feeding NUM_WB_PORTS register-file write ports through a
// round-robin arbiter that never writes the same register twice in one cycle.
module writeback_arbiter #(
  parameter int NUM_FU       = 4,
  parameter int NUM_WB_PORTS = 2,
  parameter int FIFO_DEPTH   = 2,
  parameter int DATA_W       = 32,
  parameter int REG_W        = 5
) (
  input  logic                                     CLK,
  input  logic                                     rst,
  input  logic                                     flush,
  input  logic [NUM_FU-1:0]                        fu_valid,
  input  logic [NUM_FU*DATA_W-1:0]                 fu_wdat,
  input  logic [NUM_FU*REG_W-1:0]                  fu_reg_sel,
  output logic [NUM_FU-1:0]                        fu_ready,
  output logic [NUM_WB_PORTS-1:0]                  wb_valid,
  output logic [NUM_WB_PORTS*DATA_W-1:0]           wb_wdat,
  output logic [NUM_WB_PORTS*REG_W-1:0]            wb_reg_sel,
  output logic [NUM_FU*$clog2(FIFO_DEPTH+1)-1:0]   fu_occupancy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int FU_W  = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

  logic [PTR_W-1:0]  head_q [NUM_FU];
  logic [PTR_W-1:0]  head_d [NUM_FU];
  logic [PTR_W-1:0]  tail_q [NUM_FU];
  logic [PTR_W-1:0]  tail_d [NUM_FU];
  logic [CNT_W-1:0]  count_q [NUM_FU];
  logic [CNT_W-1:0]  count_d [NUM_FU];
  logic [DATA_W-1:0] mem_data_q [NUM_FU][FIFO_DEPTH];
  logic [DATA_W-1:0] mem_data_d [NUM_FU][FIFO_DEPTH];
  logic [REG_W-1:0]  mem_reg_q [NUM_FU][FIFO_DEPTH];
  logic [REG_W-1:0]  mem_reg_d [NUM_FU][FIFO_DEPTH];

  logic [FU_W-1:0]         rr_q, rr_d;
  logic [NUM_WB_PORTS-1:0] wb_valid_q, wb_valid_d;
  logic [DATA_W-1:0]       wb_wdat_q [NUM_WB_PORTS];
  logic [DATA_W-1:0]       wb_wdat_d [NUM_WB_PORTS];
  logic [REG_W-1:0]        wb_reg_q [NUM_WB_PORTS];
  logic [REG_W-1:0]        wb_reg_d [NUM_WB_PORTS];

  logic [NUM_FU-1:0] grant;
  logic [NUM_FU-1:0] push;

  always_comb begin
    for (int c = 0; c < NUM_FU; c++) begin
      fu_ready[c] = (count_q[c] != CNT_W'(FIFO_DEPTH));
      fu_occupancy[c*CNT_W +: CNT_W] = count_q[c];
    end
  end

  always_comb begin
    wb_valid = wb_valid_q;
    for (int p = 0; p < NUM_WB_PORTS; p++) begin
      wb_wdat[p*DATA_W +: DATA_W]  = wb_wdat_q[p];
      wb_reg_sel[p*REG_W +: REG_W] = wb_reg_q[p];
    end
  end

  // Walk channels in rotated order; a head is skipped if its register is already claimed.
  always_comb begin
    int  n_grant;
    int  pos;
    int  last;
    logic conflict;
    grant      = '0;
    wb_valid_d = '0;
    for (int p = 0; p < NUM_WB_PORTS; p++) begin
      wb_wdat_d[p] = '0;
      wb_reg_d[p]  = '0;
    end
    n_grant  = 0;
    pos      = 0;
    last     = 0;
    conflict = 1'b0;
    rr_d     = rr_q;
    if (!flush) begin
      for (int k = 0; k < NUM_FU; k++) begin
        pos = int'(rr_q) + k;
        if (pos >= NUM_FU) pos = pos - NUM_FU;
        for (int c = 0; c < NUM_FU; c++) begin
          if (c == pos && count_q[c] != '0 && n_grant < NUM_WB_PORTS) begin
            conflict = 1'b0;
            for (int p = 0; p < NUM_WB_PORTS; p++) begin
              if (p < n_grant && wb_reg_d[p] == mem_reg_q[c][head_q[c]]) conflict = 1'b1;
            end
            if (!conflict) begin
              for (int p = 0; p < NUM_WB_PORTS; p++) begin
                if (p == n_grant) begin
                  wb_valid_d[p] = 1'b1;
                  wb_wdat_d[p]  = mem_data_q[c][head_q[c]];
                  wb_reg_d[p]   = mem_reg_q[c][head_q[c]];
                end
              end
              grant[c] = 1'b1;
              last     = c;
              n_grant  = n_grant + 1;
            end
          end
        end
      end
      if (n_grant > 0) rr_d = (last == NUM_FU - 1) ? '0 : FU_W'(last + 1);
    end
  end

  // x0 results are acknowledged through fu_ready but never enter the buffer.
  always_comb begin
    mem_data_d = mem_data_q;
    mem_reg_d  = mem_reg_q;
    for (int c = 0; c < NUM_FU; c++) begin
      push[c]    = fu_valid[c] & fu_ready[c] & ~flush & (fu_reg_sel[c*REG_W +: REG_W] != '0);
      head_d[c]  = head_q[c];
      tail_d[c]  = tail_q[c];
      count_d[c] = count_q[c];
      if (flush) begin
        head_d[c]  = '0;
        tail_d[c]  = '0;
        count_d[c] = '0;
      end else begin
        if (push[c]) begin
          mem_data_d[c][tail_q[c]] = fu_wdat[c*DATA_W +: DATA_W];
          mem_reg_d[c][tail_q[c]]  = fu_reg_sel[c*REG_W +: REG_W];
          tail_d[c] = tail_q[c] + 1'b1;
        end
        if (grant[c]) head_d[c] = head_q[c] + 1'b1;
        count_d[c] = count_q[c] + CNT_W'(push[c]) - CNT_W'(grant[c]);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      for (int c = 0; c < NUM_FU; c++) begin
        head_q[c]  <= '0;
        tail_q[c]  <= '0;
        count_q[c] <= '0;
      end
      rr_q       <= '0;
      wb_valid_q <= '0;
      for (int p = 0; p < NUM_WB_PORTS; p++) begin
        wb_wdat_q[p] <= '0;
        wb_reg_q[p]  <= '0;
      end
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      rr_q       <= rr_d;
      wb_valid_q <= wb_valid_d;
      wb_wdat_q  <= wb_wdat_d;
      wb_reg_q   <= wb_reg_d;
    end
  end

  always_ff @(posedge CLK) begin
    mem_data_q <= mem_data_d;
    mem_reg_q  <= mem_reg_d;
  end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Bench for writeback_arbiter: directed vector table, hand-written corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_writeback_arbiter;

  localparam int NF = 4;
  localparam int NP = 2;
  localparam int D  = 2;
  localparam int DW = 32;
  localparam int RW = 5;
  localparam int CW = 2;

  logic              CLK = 1'b0;
  logic              rst, flush;
  logic [NF-1:0]     fu_valid;
  logic [NF*DW-1:0]  fu_wdat;
  logic [NF*RW-1:0]  fu_reg_sel;
  logic [NF-1:0]     fu_ready;
  logic [NP-1:0]     wb_valid;
  logic [NP*DW-1:0]  wb_wdat;
  logic [NP*RW-1:0]  wb_reg_sel;
  logic [NF*CW-1:0]  fu_occupancy;

  always #5 CLK = ~CLK;

  writeback_arbiter #(
    .NUM_FU(NF), .NUM_WB_PORTS(NP), .FIFO_DEPTH(D), .DATA_W(DW), .REG_W(RW)
  ) dut (
    .CLK(CLK), .rst(rst), .flush(flush),
    .fu_valid(fu_valid), .fu_wdat(fu_wdat), .fu_reg_sel(fu_reg_sel),
    .fu_ready(fu_ready), .wb_valid(wb_valid), .wb_wdat(wb_wdat),
    .wb_reg_sel(wb_reg_sel), .fu_occupancy(fu_occupancy)
  );

  typedef struct { logic [RW-1:0] r; logic [DW-1:0] d; } ent_t;
  ent_t mq[NF][$];
  int   rr_m;
  logic [NP-1:0]    ev;
  logic [NP*DW-1:0] ed;
  logic [NP*RW-1:0] er;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: per-channel queues, grants chosen by scanning from rr_m with a claimed-register list.
  task automatic model_step(input logic r, input logic f, input logic [NF-1:0] v,
                            input logic [NF*RW-1:0] rs, input logic [NF*DW-1:0] wd);
    logic [NF-1:0] rdy;
    logic [NF-1:0] gr;
    logic [RW-1:0] taken[$];
    int n, last, ch;
    bit hit;
    ent_t e;
    ev = '0; ed = '0; er = '0;
    if (r || f) begin
      for (int i = 0; i < NF; i++) mq[i].delete();
      if (r) rr_m = 0;
      return;
    end
    for (int i = 0; i < NF; i++) rdy[i] = (mq[i].size() < D);
    gr = '0; n = 0; last = -1;
    for (int k = 0; k < NF; k++) begin
      ch = (rr_m + k) % NF;
      if (mq[ch].size() > 0 && n < NP) begin
        hit = 0;
        foreach (taken[j]) if (taken[j] == mq[ch][0].r) hit = 1;
        if (!hit) begin
          ev[n] = 1'b1;
          ed[n*DW +: DW] = mq[ch][0].d;
          er[n*RW +: RW] = mq[ch][0].r;
          taken.push_back(mq[ch][0].r);
          gr[ch] = 1'b1;
          last = ch;
          n++;
        end
      end
    end
    for (int i = 0; i < NF; i++) if (gr[i]) void'(mq[i].pop_front());
    for (int i = 0; i < NF; i++) begin
      if (v[i] && rdy[i] && rs[i*RW +: RW] != '0) begin
        e.r = rs[i*RW +: RW];
        e.d = wd[i*DW +: DW];
        mq[i].push_back(e);
      end
    end
    if (last >= 0) rr_m = (last + 1) % NF;
  endtask

  task automatic compare_model(input string tag);
    logic [NF*CW-1:0] eo;
    logic [NF-1:0]    erdy;
    for (int i = 0; i < NF; i++) begin
      eo[i*CW +: CW] = CW'(mq[i].size());
      erdy[i] = (mq[i].size() < D);
    end
    check({tag, ".wb_valid"}, 128'(wb_valid), 128'(ev));
    check({tag, ".wb_wdat"}, 128'(wb_wdat), 128'(ed));
    check({tag, ".wb_reg_sel"}, 128'(wb_reg_sel), 128'(er));
    check({tag, ".occupancy"}, 128'(fu_occupancy), 128'(eo));
    check({tag, ".fu_ready"}, 128'(fu_ready), 128'(erdy));
  endtask

  task automatic cycle(input logic r, input logic f, input logic [NF-1:0] v,
                       input logic [NF*RW-1:0] rs, input logic [NF*DW-1:0] wd, input string tag);
    rst = r; flush = f; fu_valid = v; fu_reg_sel = rs; fu_wdat = wd;
    @(posedge CLK);
    #1;
    model_step(r, f, v, rs, wd);
    compare_model(tag);
  endtask

  typedef struct packed {
    logic             fl;
    logic [NF-1:0]    v;
    logic [NF*RW-1:0] rs;
    logic [NF*DW-1:0] wd;
    logic [NP-1:0]    ev;
    logic [NP*RW-1:0] er;
    logic [NP*DW-1:0] ed;
    logic [NF*CW-1:0] eo;
  } vec_t;

  function automatic vec_t mk(input logic fl, input logic [3:0] v,
                              input int r0, input int r1, input int r2, input int r3,
                              input logic [31:0] d0, input logic [31:0] d1,
                              input logic [31:0] d2, input logic [31:0] d3,
                              input logic [1:0] ev_, input int er0, input logic [31:0] ed0,
                              input int er1, input logic [31:0] ed1,
                              input int o0, input int o1, input int o2, input int o3);
    vec_t t;
    t.fl = fl;
    t.v  = v;
    t.rs = {5'(r3), 5'(r2), 5'(r1), 5'(r0)};
    t.wd = {d3, d2, d1, d0};
    t.ev = ev_;
    t.er = {5'(er1), 5'(er0)};
    t.ed = {ed1, ed0};
    t.eo = {2'(o3), 2'(o2), 2'(o1), 2'(o0)};
    return t;
  endfunction

  vec_t tbl[13];

  initial begin
    rst = 1'b1; flush = 1'b0; fu_valid = '0; fu_wdat = '0; fu_reg_sel = '0; rr_m = 0;

    // single push, four-way push, same-register conflict, x0 drop
    tbl[0]  = mk(0, 4'b0100, 0,0,7,0, 0,0,32'hDEAD,0,     2'b00, 0,0,          0,0,          0,0,1,0);
    tbl[1]  = mk(0, 4'b0000, 0,0,0,0, 0,0,0,0,            2'b01, 7,32'hDEAD,   0,0,          0,0,0,0);
    tbl[2]  = mk(0, 4'b0000, 0,0,0,0, 0,0,0,0,            2'b00, 0,0,          0,0,          0,0,0,0);
    tbl[3]  = mk(0, 4'b1000, 0,0,0,9, 0,0,0,32'h33,       2'b00, 0,0,          0,0,          0,0,0,1);
    tbl[4]  = mk(0, 4'b0000, 0,0,0,0, 0,0,0,0,            2'b01, 9,32'h33,     0,0,          0,0,0,0);
    tbl[5]  = mk(0, 4'b1111, 1,2,3,4, 32'h100,32'h200,32'h300,32'h400,
                                                          2'b00, 0,0,          0,0,          1,1,1,1);
    tbl[6]  = mk(0, 4'b0000, 0,0,0,0, 0,0,0,0,            2'b11, 1,32'h100,    2,32'h200,    0,0,1,1);
    tbl[7]  = mk(0, 4'b0000, 0,0,0,0, 0,0,0,0,            2'b11, 3,32'h300,    4,32'h400,    0,0,0,0);
    tbl[8]  = mk(0, 4'b0011, 5,5,0,0, 32'h500,32'h501,0,0,2'b00, 0,0,          0,0,          1,1,0,0);
    tbl[9]  = mk(0, 4'b0000, 0,0,0,0, 0,0,0,0,            2'b01, 5,32'h500,    0,0,          0,1,0,0);
    tbl[10] = mk(0, 4'b0000, 0,0,0,0, 0,0,0,0,            2'b01, 5,32'h501,    0,0,          0,0,0,0);
    tbl[11] = mk(0, 4'b0010, 0,0,0,0, 0,32'hBAD,0,0,      2'b00, 0,0,          0,0,          0,0,0,0);
    tbl[12] = mk(0, 4'b0000, 0,0,0,0, 0,0,0,0,            2'b00, 0,0,          0,0,          0,0,0,0);

    cycle(1, 0, '0, '0, '0, "reset0");
    cycle(1, 0, '0, '0, '0, "reset1");
    check("reset.wb_valid", 128'(wb_valid), 128'(0));
    check("reset.occupancy", 128'(fu_occupancy), 128'(0));
    check("reset.fu_ready", 128'(fu_ready), 128'(4'b1111));

    for (int i = 0; i < 13; i++) begin
      cycle(0, tbl[i].fl, tbl[i].v, tbl[i].rs, tbl[i].wd, $sformatf("vec%0d", i));
      check($sformatf("tbl%0d.wb_valid", i), 128'(wb_valid), 128'(tbl[i].ev));
      check($sformatf("tbl%0d.wb_reg_sel", i), 128'(wb_reg_sel), 128'(tbl[i].er));
      check($sformatf("tbl%0d.wb_wdat", i), 128'(wb_wdat), 128'(tbl[i].ed));
      check($sformatf("tbl%0d.occupancy", i), 128'(fu_occupancy), 128'(tbl[i].eo));
    end

    // full FIFO on channel 0 while conflicts keep it from draining
    cycle(1, 0, '0, '0, '0, "full.rst");
    cycle(0, 0, 4'b0001, {5'd0,5'd0,5'd0,5'd9}, {32'h0,32'h0,32'h0,32'h900}, "full.c1");
    cycle(0, 0, 4'b1111, {5'd5,5'd7,5'd5,5'd5}, {32'hB3,32'hB2,32'hB1,32'hA0}, "full.c2");
    check("full.c2.wb_reg0", 128'(wb_reg_sel[4:0]), 128'(9));
    cycle(0, 0, 4'b0001, {5'd0,5'd0,5'd0,5'd5}, {32'h0,32'h0,32'h0,32'hA1}, "full.c3");
    check("full.c3.occ0", 128'(fu_occupancy[1:0]), 128'(2));
    check("full.c3.ready0", 128'(fu_ready[0]), 128'(0));
    check("full.c3.wb_wdat", 128'(wb_wdat), 128'({32'hB2, 32'hB1}));
    cycle(0, 0, 4'b0001, {5'd0,5'd0,5'd0,5'd5}, {32'h0,32'h0,32'h0,32'hA2}, "full.c4");
    check("full.c4.wb_valid", 128'(wb_valid), 128'(2'b01));
    check("full.c4.wb_wdat0", 128'(wb_wdat[31:0]), 128'(32'hB3));
    check("full.c4.ready0", 128'(fu_ready[0]), 128'(0));
    cycle(0, 0, 4'b0001, {5'd0,5'd0,5'd0,5'd5}, {32'h0,32'h0,32'h0,32'hA2}, "full.c5");
    check("full.c5.wb_wdat0", 128'(wb_wdat[31:0]), 128'(32'hA0));
    check("full.c5.occ0", 128'(fu_occupancy[1:0]), 128'(1));
    cycle(0, 0, 4'b0001, {5'd0,5'd0,5'd0,5'd5}, {32'h0,32'h0,32'h0,32'hA2}, "full.c6");
    check("full.c6.wb_wdat0", 128'(wb_wdat[31:0]), 128'(32'hA1));
    cycle(0, 0, '0, '0, '0, "full.c7");
    check("full.c7.wb_wdat0", 128'(wb_wdat[31:0]), 128'(32'hA2));
    check("full.c7.occ0", 128'(fu_occupancy[1:0]), 128'(0));

    // flush with buffered entries and a same-cycle push; rr_ptr must hold at 1
    cycle(0, 0, 4'b0011, {5'd0,5'd0,5'd4,5'd3}, {32'h0,32'h0,32'h4A,32'h3A}, "flush.f1");
    cycle(0, 1, 4'b0100, {5'd0,5'd6,5'd0,5'd0}, {32'h0,32'h6A,32'h0,32'h0}, "flush.f2");
    check("flush.f2.occupancy", 128'(fu_occupancy), 128'(0));
    check("flush.f2.wb_valid", 128'(wb_valid), 128'(0));
    cycle(0, 0, '0, '0, '0, "flush.f3");
    check("flush.f3.wb_valid", 128'(wb_valid), 128'(0));
    cycle(0, 0, '0, '0, '0, "flush.f4");
    check("flush.f4.wb_valid", 128'(wb_valid), 128'(0));
    cycle(0, 0, 4'b0111, {5'd0,5'd3,5'd2,5'd1}, {32'h0,32'h30,32'h20,32'h10}, "flush.f5");
    cycle(0, 0, '0, '0, '0, "flush.f6");
    check("flush.f6.wb_reg_sel", 128'(wb_reg_sel), 128'({5'd3, 5'd2}));
    cycle(0, 0, '0, '0, '0, "flush.f7");
    check("flush.f7.wb_reg_sel", 128'(wb_reg_sel), 128'({5'd0, 5'd1}));

    // reset with three buffered entries, also asserting flush and pushes
    cycle(0, 0, 4'b0111, {5'd0,5'd10,5'd10,5'd10}, {32'h0,32'hC2,32'hC1,32'hC0}, "rst.r1");
    check("rst.r1.occupancy", 128'(fu_occupancy), 128'({2'd0,2'd1,2'd1,2'd1}));
    cycle(1, 1, 4'b1111, {5'd11,5'd11,5'd11,5'd11}, {4{32'hFFFF_FFFF}}, "rst.r2");
    check("rst.r2.wb_valid", 128'(wb_valid), 128'(0));
    check("rst.r2.wb_wdat", 128'(wb_wdat), 128'(0));
    check("rst.r2.wb_reg_sel", 128'(wb_reg_sel), 128'(0));
    check("rst.r2.occupancy", 128'(fu_occupancy), 128'(0));
    check("rst.r2.fu_ready", 128'(fu_ready), 128'(4'b1111));
    cycle(0, 0, '0, '0, '0, "rst.r3");
    check("rst.r3.wb_valid", 128'(wb_valid), 128'(0));
    cycle(0, 0, '0, '0, '0, "rst.r4");
    check("rst.r4.wb_valid", 128'(wb_valid), 128'(0));

    // randomized traffic with a small register set to provoke conflicts
    for (int n = 0; n < 1500; n++) begin
      logic [NF*RW-1:0] rs;
      logic [NF*DW-1:0] wd;
      for (int c = 0; c < NF; c++) begin
        rs[c*RW +: RW] = RW'($urandom_range(0, 3));
        wd[c*DW +: DW] = $urandom;
      end
      cycle(logic'($urandom_range(0, 99) == 0), logic'($urandom_range(0, 49) == 0),
            NF'($urandom), rs, wd, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
